// File: rtl/mem_line_responder.sv
// Fixed-latency 128-bit line memory responder with a side preload port.
// Define MEM_LINE_RESP_WRITE_EN to enable the write path; otherwise read-only.
module mem_line_responder #(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [27:0]           mem_addr,
  input  logic [127:0]          mem_wdata,
  output logic [127:0]          mem_rdata,
  output logic                  mem_ready,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [127:0]          ld_data
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned ADDR_W = 28;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [LINE_W-1:0]     store [DEPTH];
  logic                  accept_c;
  logic                  req_held_c;
  logic                  rd_zero_c;
  logic                  unused_ok;

`ifdef MEM_LINE_RESP_WRITE_EN
  logic              wr_q, wr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  // Read+write together is a write; abort follows whichever line was captured.
  assign accept_c   = mem_read | mem_write;
  assign req_held_c = wr_q ? mem_write : mem_read;
  assign rd_zero_c  = wr_d;
  assign unused_ok  = ^mem_addr[ADDR_W-1:DEPTH_LOG2];
`else
  assign accept_c   = mem_read;
  assign req_held_c = mem_read;
  assign rd_zero_c  = 1'b0;
  assign unused_ok  = ^{mem_addr[ADDR_W-1:DEPTH_LOG2], mem_write, mem_wdata};
`endif

  // Next-state and capture logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
`ifdef MEM_LINE_RESP_WRITE_EN
    wr_d    = wr_q;
    wdata_d = wdata_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          idx_d   = mem_addr[DEPTH_LOG2-1:0];
`ifdef MEM_LINE_RESP_WRITE_EN
          wr_d    = mem_write;
          wdata_d = mem_wdata;
`endif
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (!req_held_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; read data is latched on RESP entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
`ifdef MEM_LINE_RESP_WRITE_EN
      wr_q      <= 1'b0;
      wdata_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      mem_ready <= (state_d == RESP);
      if (state_d == RESP) mem_rdata <= rd_zero_c ? '0 : store[idx_d];
`ifdef MEM_LINE_RESP_WRITE_EN
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
`endif
    end
  end

  // Line store is not reset; a committing RESP write overrides a same-index preload.
  always_ff @(posedge clk) begin
    if (ld_en) store[ld_addr] <= ld_data;
`ifdef MEM_LINE_RESP_WRITE_EN
    if (rst_n && (state_q == RESP) && wr_q) store[idx_q] <= wdata_q;
`endif
  end

endmodule
